// File: rtl/i2c_master_controller.sv
// rtl/i2c_master_controller.sv - single-clock I2C master running one 16-bit register transaction per command
//
// Purpose: issues a complete write (START, addr+W, reg, data_hi, data_lo, STOP)
// or read (START, addr+R, data_hi, data_lo, STOP) per accepted command and
// reports completion plus slave ACK status.
//
// Ports:
//   clk       system clock, all logic on rising edge
//   rst       asynchronous active-high reset
//   start     1-cycle command strobe, accepted only while busy=0
//   rw        0=write, 1=read (latched on accept)
//   dev_addr  7-bit slave address (latched on accept)
//   reg_addr  register address, used by writes only (latched on accept)
//   wdata     write data, [15:8] sent first (latched on accept)
//   rdata     read data, loaded at the end of a successful read
//   busy      high from the cycle after accept until the done cycle
//   done      1-cycle pulse when the transaction ends
//   ack_err   set when any slave ACK slot reads 1, cleared on next accept
//   scl, sda  open-drain bus lines: driven 0 or released (z)

module i2c_master_controller #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  inout  wire         scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WR_HI,
    ST_WR_HI_ACK,
    ST_WR_LO,
    ST_WR_LO_ACK,
    ST_RD_HI,
    ST_RD_HI_ACK,
    ST_RD_LO,
    ST_RD_LO_NACK,
    ST_STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_q;
  logic [15:0] div_q;
  logic [1:0]  qtr_q;
  logic [2:0]  bit_q;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [15:0] wdata_q;
  logic [15:0] rx_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        done_q;
  logic        ack_err_q;
  logic        scl_low_q;
  logic        sda_low_q;
  logic        sda_meta_q;
  logic        sda_sync_q;

  logic        tick;
  logic        tx_bit;
  logic        scl_low_d;
  logic        sda_low_d;
  logic        slave_ack_slot;
  logic        rx_slot;
  logic        byte_slot;
  logic [7:0]  addr_byte;

  assign tick           = (div_q == DIV_LAST);
  assign addr_byte      = {dev_q, rw_q};
  assign slave_ack_slot = state_q inside {ST_ADDR_ACK, ST_REG_ACK, ST_WR_HI_ACK, ST_WR_LO_ACK};
  assign rx_slot        = state_q inside {ST_RD_HI, ST_RD_LO};
  assign byte_slot      = state_q inside {ST_ADDR, ST_REG, ST_WR_HI, ST_WR_LO, ST_RD_HI, ST_RD_LO};

  // Bit the master puts on SDA in the current phase; 1 means released.
  always_comb begin
    tx_bit = 1'b1;
    case (state_q)
      ST_ADDR:  tx_bit = addr_byte[bit_q];
      ST_REG:   tx_bit = reg_q[bit_q];
      ST_WR_HI: tx_bit = wdata_q[{1'b1, bit_q}];
      ST_WR_LO: tx_bit = wdata_q[{1'b0, bit_q}];
      default:  tx_bit = 1'b1;
    endcase
  end

  // Line levels for the current state/quarter; registered into the pad
  // enables so the bus never sees combinational glitches.
  always_comb begin
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
      end
      ST_START: begin
        scl_low_d = (qtr_q == 2'd3);
        sda_low_d = qtr_q[1];
      end
      ST_STOP: begin
        scl_low_d = (qtr_q == 2'd0);
        sda_low_d = (qtr_q != 2'd3);
      end
      default: begin
        scl_low_d = ~qtr_q[1];
        sda_low_d = ~tx_bit | (state_q == ST_RD_HI_ACK);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      rw_q       <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
      done_q     <= 1'b0;

      if (state_q == ST_IDLE) begin
        div_q <= '0;
        qtr_q <= '0;
        if (start && !busy_q) begin
          rw_q      <= rw;
          dev_q     <= dev_addr;
          reg_q     <= reg_addr;
          wdata_q   <= wdata;
          bit_q     <= 3'd7;
          ack_err_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= ST_START;
        end
      end else if (tick) begin
        div_q <= '0;
        qtr_q <= qtr_q + 2'd1;

        // Single SDA sample per phase, at the q2->q3 boundary (mid SCL-high).
        if (qtr_q == 2'd2) begin
          if (slave_ack_slot && sda_sync_q) begin
            ack_err_q <= 1'b1;
          end
          if (rx_slot) begin
            rx_q <= {rx_q[14:0], sda_sync_q};
          end
        end

        if (qtr_q == 2'd3) begin
          // Bit counter wraps 0->7 on the last bit, so it is ready for the next byte.
          if (byte_slot) begin
            bit_q <= bit_q - 3'd1;
          end
          case (state_q)
            ST_START:      state_q <= ST_ADDR;
            ST_ADDR:       if (bit_q == 3'd0) state_q <= ST_ADDR_ACK;
            ST_ADDR_ACK:   state_q <= ack_err_q ? ST_STOP : (rw_q ? ST_RD_HI : ST_REG);
            ST_REG:        if (bit_q == 3'd0) state_q <= ST_REG_ACK;
            ST_REG_ACK:    state_q <= ack_err_q ? ST_STOP : ST_WR_HI;
            ST_WR_HI:      if (bit_q == 3'd0) state_q <= ST_WR_HI_ACK;
            ST_WR_HI_ACK:  state_q <= ack_err_q ? ST_STOP : ST_WR_LO;
            ST_WR_LO:      if (bit_q == 3'd0) state_q <= ST_WR_LO_ACK;
            ST_WR_LO_ACK:  state_q <= ST_STOP;
            ST_RD_HI:      if (bit_q == 3'd0) state_q <= ST_RD_HI_ACK;
            ST_RD_HI_ACK:  state_q <= ST_RD_LO;
            ST_RD_LO:      if (bit_q == 3'd0) state_q <= ST_RD_LO_NACK;
            ST_RD_LO_NACK: state_q <= ST_STOP;
            ST_STOP: begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (rw_q && !ack_err_q) begin
                rdata_q <= rx_q;
              end
            end
            default:       state_q <= ST_IDLE;
          endcase
        end
      end else begin
        div_q <= div_q + 16'd1;
      end
    end
  end

  assign scl     = scl_low_q ? 1'b0 : 1'bz;
  assign sda     = sda_low_q ? 1'b0 : 1'bz;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// tb/tb_i2c_master_controller.sv - directed self-checking bench for i2c_master_controller
module tb_i2c_master_controller;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [6:0]  dev_addr = 7'h00;
  logic [7:0]  reg_addr = 8'h00;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        ack_err;
  tri1         scl;
  tri1         sda;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cyc = 0;

  i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .busy(busy),
    .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Slave model at 7'h40: write = reg, hi, lo; read returns stored hi, lo.
  logic       s_drv = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       c_scl;
  logic       c_sda;
  int         s_mode = 0;
  int         s_cnt = 0;
  int         s_idx = 0;
  logic [7:0] s_sr = 8'h00;
  logic [7:0] s_hi = 8'h00;
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_reg = 8'hFF;
  logic [15:0] s_data = 16'h0000;
  logic       s_rd = 1'b0;
  logic       s_mack_bit = 1'b1;
  logic [1:0] s_mack_log = 2'b11;
  int         s_mack_n = 0;
  int         s_acks = 0;
  int         s_stops = 0;

  assign sda = s_drv ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    c_scl = scl;
    c_sda = sda;
    if (p_scl && c_scl && p_sda && !c_sda) begin
      s_mode = 1; s_cnt = 0; s_idx = 0; s_drv = 1'b0;
    end else if (p_scl && c_scl && !p_sda && c_sda) begin
      s_mode = 0; s_drv = 1'b0; s_stops++;
    end else if (!p_scl && c_scl) begin
      if (s_mode == 1) begin s_sr = {s_sr[6:0], c_sda}; s_cnt++; end
      else if (s_mode == 4) s_mack_bit = c_sda;
    end else if (p_scl && !c_scl) begin
      case (s_mode)
        1: if (s_cnt == 8) begin
             s_cnt = 0;
             if (s_idx == 0) begin
               if (s_sr[7:1] == 7'h40) begin s_rd = s_sr[0]; s_drv = 1'b1; s_mode = 2; s_acks++; end
               else s_mode = 0;
             end else begin
               if (s_idx == 1) s_reg = s_sr;
               else if (s_idx == 2) s_hi = s_sr;
               else s_data = {s_hi, s_sr};
               s_drv = 1'b1; s_mode = 2; s_acks++;
             end
             s_idx++;
           end
        2: begin
             s_drv = 1'b0;
             if (s_rd) begin s_tx = s_data[15:8]; s_mode = 3; s_cnt = 1; s_drv = !s_tx[7]; end
             else s_mode = 1;
           end
        3: if (s_cnt == 8) begin s_drv = 1'b0; s_mode = 4; end
           else begin s_drv = !s_tx[7 - s_cnt]; s_cnt++; end
        4: begin
             s_mack_log = {s_mack_log[0], s_mack_bit};
             s_mack_n++;
             if (!s_mack_bit) begin s_tx = s_data[7:0]; s_mode = 3; s_cnt = 1; s_drv = !s_tx[7]; end
             else s_mode = 0;
           end
        default: ;
      endcase
    end
    p_scl = c_scl;
    p_sda = c_sda;
  end

  task automatic issue_cmd(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [15:0] wd);
    @(negedge clk);
    rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int lat, output bit to);
    to = 1'b1;
    lat = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin to = 1'b0; lat = cyc - acc_cyc; break; end
    end
  endtask

  task automatic test_reset;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    n_tests++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    n_tests++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_write;
    int lat; bit to; int a0; int st0;
    a0 = s_acks; st0 = s_stops;
    issue_cmd(1'b0, 7'h40, 8'h00, 16'hA53C);
    wait_done(lat, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL write_timeout: no done within bound"); end
    n_tests++; if (lat !== 608) begin n_fail++; $display("FAIL write_latency: got %0d want 608", lat); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL write_ack_err: got %b want 0", ack_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_at_done: got %b want 0", busy); end
    n_tests++; if (s_acks - a0 !== 4) begin n_fail++; $display("FAIL write_acks: got %0d want 4", s_acks - a0); end
    n_tests++; if (s_reg !== 8'h00) begin n_fail++; $display("FAIL write_reg: got %h want 00", s_reg); end
    n_tests++; if (s_data !== 16'hA53C) begin n_fail++; $display("FAIL write_data: got %h want a53c", s_data); end
    n_tests++; if (s_stops - st0 !== 1) begin n_fail++; $display("FAIL write_stop: got %0d want 1", s_stops - st0); end
  endtask

  task automatic test_read;
    int lat; bit to; int a0; int m0;
    a0 = s_acks; m0 = s_mack_n;
    issue_cmd(1'b1, 7'h40, 8'h00, 16'h0000);
    wait_done(lat, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL read_timeout: no done within bound"); end
    n_tests++; if (lat !== 464) begin n_fail++; $display("FAIL read_latency: got %0d want 464", lat); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL read_ack_err: got %b want 0", ack_err); end
    n_tests++; if (rdata !== 16'hA53C) begin n_fail++; $display("FAIL read_rdata: got %h want a53c", rdata); end
    n_tests++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL read_rw_bit: got %b want 1", s_rd); end
    n_tests++; if (s_acks - a0 !== 1) begin n_fail++; $display("FAIL read_addr_ack: got %0d want 1", s_acks - a0); end
    n_tests++; if (s_mack_n - m0 !== 2) begin n_fail++; $display("FAIL read_master_slots: got %0d want 2", s_mack_n - m0); end
    n_tests++; if (s_mack_log !== 2'b01) begin n_fail++; $display("FAIL read_ack_nack: got %b want 01", s_mack_log); end
  endtask

  task automatic test_addr_nack;
    int lat; bit to; int st0;
    st0 = s_stops;
    issue_cmd(1'b0, 7'h21, 8'h00, 16'hBEEF);
    wait_done(lat, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL nack_timeout: no done within bound"); end
    n_tests++; if (lat !== 176) begin n_fail++; $display("FAIL nack_latency: got %0d want 176", lat); end
    n_tests++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
    n_tests++; if (s_stops - st0 !== 1) begin n_fail++; $display("FAIL nack_stop: got %0d want 1", s_stops - st0); end
    n_tests++; if (rdata !== 16'hA53C) begin n_fail++; $display("FAIL nack_rdata_kept: got %h want a53c", rdata); end
    n_tests++; if (s_data !== 16'hA53C) begin n_fail++; $display("FAIL nack_slave_data: got %h want a53c", s_data); end
  endtask

  task automatic test_ignore_and_reset;
    int lat; bit to; int dc0;
    issue_cmd(1'b0, 7'h40, 8'h00, 16'h1234);
    repeat (100) @(negedge clk);
    rw = 1'b1; dev_addr = 7'h21; wdata = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", busy); end
    wait_done(lat, to);
    n_tests++; if (lat !== 608) begin n_fail++; $display("FAIL ignore_latency: got %0d want 608", lat); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL ignore_ack_err: got %b want 0", ack_err); end
    n_tests++; if (s_data !== 16'h1234) begin n_fail++; $display("FAIL ignore_data: got %h want 1234", s_data); end

    issue_cmd(1'b0, 7'h40, 8'h00, 16'h5678);
    repeat (308) @(negedge clk);
    n_tests++; if (scl !== 1'b0) begin n_fail++; $display("FAIL wrhi_scl_low: got %b want 0", scl); end
    n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL wrhi_sda_bit7: got %b want 0", sda); end
    dc0 = done_cnt;
    rst = 1'b1;
    #1;
    n_tests++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rst_mid_scl: got %b want 1", scl); end
    n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rst_mid_sda: got %b want 1", sda); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    n_tests++; if (done_cnt !== dc0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, dc0); end

    issue_cmd(1'b0, 7'h40, 8'h00, 16'h0F0F);
    wait_done(lat, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL post_rst_timeout: no done within bound"); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL post_rst_ack_err: got %b want 0", ack_err); end
    n_tests++; if (s_data !== 16'h0F0F) begin n_fail++; $display("FAIL post_rst_data: got %h want 0f0f", s_data); end
  endtask

  task automatic test_back_to_back;
    int lat; bit to;
    issue_cmd(1'b0, 7'h21, 8'h00, 16'h0000);
    wait_done(lat, to);
    n_tests++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL b2b_first_nack: got %b want 1", ack_err); end
    issue_cmd(1'b0, 7'h40, 8'h00, 16'hC3A5);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy %b want 1", busy); end
    n_tests++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL b2b_ack_err_clear: got %b want 0", ack_err); end
    repeat (10) @(negedge clk);
    n_tests++; if (scl !== 1'b1) begin n_fail++; $display("FAIL b2b_start_scl: got %b want 1", scl); end
    n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL b2b_start_sda: got %b want 0", sda); end
    wait_done(lat, to);
    n_tests++; if (lat !== 608) begin n_fail++; $display("FAIL b2b_latency: got %0d want 608", lat); end
    n_tests++; if (s_data !== 16'hC3A5) begin n_fail++; $display("FAIL b2b_data: got %h want c3a5", s_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_ignore_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
